// File: rtl/sr_flip_flop.sv
// Bank of WIDTH clocked SR storage bits with complementary outputs,
// parameter-selected S=R=1 resolution and per-bit/sticky invalid-input flags.
module sr_flip_flop #(
  parameter int WIDTH       = 1,
  parameter int SR11_MODE   = 0,
  parameter     RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] invalid,
  output logic             err_sticky
);

  // A reset constant narrower than the bank is replicated from its bit 0.
  localparam int               RV_BITS = $bits(RESET_VALUE);
  localparam logic [WIDTH+31:0] RV_EXT = (WIDTH+32)'(RESET_VALUE);
  localparam logic [WIDTH-1:0] RST_VEC = (RV_BITS >= WIDTH) ? RV_EXT[WIDTH-1:0]
                                                            : {WIDTH{RV_EXT[0]}};

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] base_next;
  logic [WIDTH-1:0] q_next;

  assign both = s & r;

  // base_next covers hold/set/clear and leaves S=R=1 bits holding;
  // the mode then rewrites only those conflicting bits.
  always_comb begin
    base_next = (q_reg | (s & ~r)) & ~(r & ~s);
    q_next    = base_next;
    case (SR11_MODE)
      0:       q_next = base_next & ~both;
      1:       q_next = base_next | both;
      2:       q_next = base_next;
      3:       q_next = base_next ^ both;
      default: q_next = base_next & ~both;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg      <= RST_VEC;
      invalid    <= '0;
      err_sticky <= 1'b0;
    end else begin
      q_reg   <= q_next;
      invalid <= both;
      if (|both) err_sticky <= 1'b1;
    end
  end

  assign q  = q_reg;
  assign qn = ~q_reg;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed self-checking bench: default, set/hold/toggle S=R=1 modes and a
// 4-bit bank with a non-zero reset value, all sharing one clock and reset.
module tb_sr_flip_flop;

  logic clk;
  logic rst_n;
  logic s1, r1;
  logic [3:0] s4, r4;

  logic q0, qn0, inv0, err0;
  logic q1, qn1, inv1, err1;
  logic q2, qn2, inv2, err2;
  logic q3, qn3, inv3, err3;
  logic [3:0] qw, qnw, invw;
  logic errw;

  int checks = 0;
  int errors = 0;

  sr_flip_flop #(.WIDTH(1), .SR11_MODE(0), .RESET_VALUE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q0), .qn(qn0), .invalid(inv0), .err_sticky(err0));

  sr_flip_flop #(.WIDTH(1), .SR11_MODE(1), .RESET_VALUE(0)) d1 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q1), .qn(qn1), .invalid(inv1), .err_sticky(err1));

  sr_flip_flop #(.WIDTH(1), .SR11_MODE(2), .RESET_VALUE(0)) d2 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q2), .qn(qn2), .invalid(inv2), .err_sticky(err2));

  sr_flip_flop #(.WIDTH(1), .SR11_MODE(3), .RESET_VALUE(0)) d3 (
    .clk(clk), .rst_n(rst_n), .s(s1), .r(r1),
    .q(q3), .qn(qn3), .invalid(inv3), .err_sticky(err3));

  sr_flip_flop #(.WIDTH(4), .SR11_MODE(0), .RESET_VALUE(4'b1010)) dw (
    .clk(clk), .rst_n(rst_n), .s(s4), .r(r4),
    .q(qw), .qn(qnw), .invalid(invw), .err_sticky(errw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 unit after the next rising edge.
  task automatic apply_stimulus(input logic sv, input logic rv,
                                input logic [3:0] swv, input logic [3:0] rwv);
    @(negedge clk);
    s1 = sv;
    r1 = rv;
    s4 = swv;
    r4 = rwv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_output4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 1'b0;
    r1 = 1'b0;
    s4 = 4'b0000;
    r4 = 4'b0000;
    #12;

    // Power-on reset values
    check_output("rst_q", q0, 1'b0);
    check_output("rst_qn", qn0, 1'b1);
    check_output("rst_invalid", inv0, 1'b0);
    check_output("rst_err", err0, 1'b0);
    check_output4("rst_w_q", qw, 4'b1010);
    check_output4("rst_w_qn", qnw, 4'b0101);
    release_reset();

    // Basic set / reset / hold
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    check_output("set_q", q0, 1'b1);
    check_output("set_qn", qn0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'b0000, 4'b0000);
    check_output("clr_q", q0, 1'b0);
    check_output("clr_qn", qn0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("hold1_q", q0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("hold2_q", q0, 1'b0);
    check_output("hold2_err", err0, 1'b0);

    // Asynchronous reset mid-cycle from q=1, checked before any clock edge
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    check_output("preasync_q", q0, 1'b1);
    check_output("preasync_q_mode1", q1, 1'b1);
    s1 = 1'b0;
    pulse_reset();
    check_output("async_q", q0, 1'b0);
    check_output("async_qn", qn0, 1'b1);
    check_output("async_q_mode1", q1, 1'b0);
    check_output("async_invalid", inv0, 1'b0);
    check_output("async_err", err0, 1'b0);
    release_reset();

    // Forbidden input in reset-dominant mode
    apply_stimulus(1'b1, 1'b0, 4'b0000, 4'b0000);
    check_output("pre11_q", q0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_output("m0_q", q0, 1'b0);
    check_output("m0_qn", qn0, 1'b1);
    check_output("m0_invalid", inv0, 1'b1);
    check_output("m0_err", err0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("m0_invalid_clear", inv0, 1'b0);
    check_output("m0_err_sticky1", err0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("m0_err_sticky2", err0, 1'b1);
    pulse_reset();
    check_output("m0_err_cleared", err0, 1'b0);
    release_reset();

    // Forbidden input held for 3 edges from q=0 in every mode
    apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_output("e1_m0_q", q0, 1'b0);
    check_output("e1_m1_q", q1, 1'b1);
    check_output("e1_m2_q", q2, 1'b0);
    check_output("e1_m3_q", q3, 1'b1);
    check_output("e1_m1_qn", qn1, 1'b0);
    check_output("e1_m3_qn", qn3, 1'b0);
    check_output("e1_m2_invalid", inv2, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_output("e2_m1_q", q1, 1'b1);
    check_output("e2_m2_q", q2, 1'b0);
    check_output("e2_m2_qn", qn2, 1'b1);
    check_output("e2_m3_q", q3, 1'b0);
    check_output("e2_m3_qn", qn3, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 4'b0000);
    check_output("e3_m1_q", q1, 1'b1);
    check_output("e3_m2_q", q2, 1'b0);
    check_output("e3_m3_q", q3, 1'b1);
    check_output("e3_m3_qn", qn3, 1'b0);
    check_output("e3_m3_err", err3, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output("after11_m3_hold", q3, 1'b1);
    check_output("after11_m3_invalid", inv3, 1'b0);

    // Glitch immunity: s pulses high strictly between rising edges
    @(posedge clk);
    #2 s1 = 1'b1;
    #2 s1 = 1'b0;
    @(posedge clk);
    #1;
    check_output("glitch_q", q0, 1'b0);
    check_output("glitch_m2_q", q2, 1'b0);

    // Multi-bit independence on the 4-bit bank (reset value 1010)
    apply_stimulus(1'b0, 1'b0, 4'b0101, 4'b1000);
    check_output4("w_q", qw, 4'b0111);
    check_output4("w_qn", qnw, 4'b1000);
    check_output4("w_invalid0", invw, 4'b0000);
    check_output("w_err0", errw, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'b0011, 4'b0011);
    check_output4("w11_q", qw, 4'b0100);
    check_output4("w11_qn", qnw, 4'b1011);
    check_output4("w11_invalid", invw, 4'b0011);
    check_output("w11_err", errw, 1'b1);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000);
    check_output4("w_invalid_clear", invw, 4'b0000);
    check_output("w_err_sticky", errw, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_flip_flop.md
Name: sr_flip_flop

Overview:
- Clocked set/reset flip-flop bank: WIDTH independent SR storage bits sampled on the rising clock edge, with complementary outputs.
- Deterministic, parameter-selected resolution of the forbidden S=R=1 input, plus per-bit and sticky flags reporting that input.
- Used as a generic control/status latch (set by one event, cleared by another) in control paths.

Parameters:
- WIDTH, 1, number of independent SR bits (>=1).
- SR11_MODE, 0, S=R=1 policy: 0 = reset-dominant (q<=0), 1 = set-dominant (q<=1), 2 = hold, 3 = toggle.
- RESET_VALUE, 0, per-bit value of q after reset; a WIDTH-bit constant, replicated from bit 0 if narrower.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s  input  WIDTH  per-bit set request.
- r  input  WIDTH  per-bit reset request.
- q  output  WIDTH  stored state.
- qn  output  WIDTH  complement of q.
- invalid  output  WIDTH  per-bit registered flag: bit i high for the cycle after s[i]=r[i]=1 was sampled.
- err_sticky  output  1  goes high on any sampled S=R=1 condition; stays high until reset.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asserted asynchronously at any time):
  - q = RESET_VALUE immediately, qn = ~RESET_VALUE.
  - invalid = 0, err_sticky = 0.
  - State holds while rst_n is low, regardless of clk, s or r.
- Reset release is synchronous-safe: the first state update happens on the first rising clk edge with rst_n=1.
- Per bit i, at rising clk edge (rst_n=1), next-state table:
  - s=0, r=0: q holds.
  - s=1, r=0: q <= 1.
  - s=0, r=1: q <= 0.
  - s=1, r=1: q follows SR11_MODE:
    - 0: q <= 0.
    - 1: q <= 1.
    - 2: q holds.
    - 3: q <= ~q.
- Latency: one clock edge from sampled s/r to q. No combinational path from s/r to any output.
- qn is always exactly ~q, bitwise, including during and after reset. q and qn never have the same value and never go X/Z once reset has been applied.
- invalid[i] is registered: set to (s[i] & r[i]) at each edge, so it is high for exactly the cycles following edges at which both were sampled high.
- err_sticky: set at an edge where any bit has s&r=1; only rst_n clears it.
- Changes on s/r between edges have no effect; only the value present at the rising edge matters.
- Reset mid-operation overrides everything, including a pending S=R=1. There is no clock-enable.
- Bits are fully independent: different bits may set, reset, hold and see S=R=1 in the same cycle.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with q=1 -> q=0, qn=1, invalid=0, err_sticky=0 immediately, before any clk edge.
- Sequence (WIDTH=1, default params; 10-unit clock period; stimulus changes on the falling edge):
  - s=1,r=0 -> q=1, qn=0 after the next rising edge.
  - then s=0,r=1 -> q=0, qn=1.
  - then s=0,r=0 -> q=0 held for two edges.
- Invalid input, default mode: from q=1, apply s=1,r=1 -> q=0, qn=1, invalid=1 for one cycle. Then s=r=0 -> invalid=0, err_sticky stays 1 until rst_n pulse.
- Invalid input, other modes: from q=0, apply s=r=1 for 3 edges.
  - SR11_MODE=1 -> q=1.
  - SR11_MODE=2 -> q stays 0.
  - SR11_MODE=3 -> q toggles 1,0,1.
  - qn=~q throughout in every mode.
- Multi-bit independence: WIDTH=4, RESET_VALUE=4'b1010, s=4'b0101, r=4'b1000 -> q=4'b0111 after one edge. Then s=4'b0011, r=4'b0011 -> invalid=4'b0011, err_sticky=1.
- Glitch immunity: pulse s high only between rising edges -> q unchanged.
